fft_frame_feeder: RTL and testbench
===================================

# fft_frame_feeder

Parametrised front end that turns a free-running stream of audio samples into framed Avalon-ST packets for the FFT core sink. Buffers incoming samples in a small FIFO, honours `sink_ready` backpressure, generates `sink_sop`/`sink_eop` on an N-point frame boundary, latches the transform direction per frame, and flags sample loss. Sits between the audio codec sample path and the FFT IP; it replaces the fixed-length, ready-ignoring frame counter.

## Interface
Parameters:
- `DATA_W`, 16, sample width; also the width of `sink_real`/`sink_imag`.
- `PTS_LOG2`, 10, log2 of frame length; N = 2^PTS_LOG2.
- `FIFO_LOG2`, 3, log2 of FIFO depth; D = 2^FIFO_LOG2.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `in_sample`  in  DATA_W  signed audio sample.
- `in_valid`  in  1  one-cycle strobe; sample is pushed on that edge. No backpressure to the source.
- `enable`  in  1  permits streaming; sampled at frame boundaries.
- `inverse_req`  in  1  requested direction for the next frame.
- `sink_ready`  in  1  FFT core ready.
- `sink_valid`  out  1  head sample valid.
- `sink_sop`  out  1  first point of frame.
- `sink_eop`  out  1  last point of frame.
- `sink_real`  out  DATA_W  FIFO head sample.
- `sink_imag`  out  DATA_W  constant 0.
- `sink_error`  out  2  constant 2'b00.
- `inverse`  out  1  direction latched for the current frame.
- `fft_pts`  out  PTS_LOG2+1  constant N.
- `overflow`  out  1  sticky; a sample was dropped.
- `frame_count`  out  16  completed frames, wraps modulo 2^16.

## Operation
- FIFO: D entries, show-ahead. `sink_real` is the head entry. Occupancy counter is FIFO_LOG2+1 bits wide.
- Push: occurs on `in_valid` when the FIFO is not full, or when it is full and a pop happens on the same edge.
- Pop: occurs on a transfer, defined as `sink_valid && sink_ready`.
- Drop: `in_valid` with the FIFO full and no pop discards the sample and sets `overflow`. `overflow` clears only on `reset`.
- State machine, IDLE:
  - `sink_valid` = 0; the FIFO still accepts pushes.
  - On an edge with `enable`=1: latch `inverse` <= `inverse_req`, point index <= 0, go to STREAM.
- State machine, STREAM:
  - `sink_valid` = FIFO not empty.
  - Each transfer increments the point index (PTS_LOG2 bits).
  - `sink_sop` = `sink_valid && index==0`.
  - `sink_eop` = `sink_valid && index==N-1`.
- End of frame (transfer with index N-1):
  - index wraps to 0 and `frame_count` increments.
  - If `enable`=1, stay in STREAM and re-latch `inverse` <= `inverse_req`; the next frame is back-to-back.
  - Else go to IDLE.
- Deasserting `enable` mid-frame never truncates a frame.
- FIFO underrun mid-frame drops `sink_valid` only. The index holds and the frame resumes when data arrives.
- While `sink_valid`=1 and `sink_ready`=0, `sink_real`, `sink_sop` and `sink_eop` hold stable (Avalon-ST rule).

## Timing
- Reset values:
  - State IDLE; FIFO empty; index 0.
  - `sink_valid`/`sink_sop`/`sink_eop`/`inverse`/`overflow` = 0; `frame_count` = 0.
  - `sink_real` = 0; `sink_imag` = 0; `sink_error` = 00; `fft_pts` = N.
- Reset mid-frame flushes the FIFO and abandons the frame. The next frame starts with `sink_sop`.
- Latency: a sample pushed on edge E appears on `sink_real` with `sink_valid`=1 in the cycle after E, if in STREAM with an empty FIFO.
- IDLE to STREAM takes one edge. `sink_valid` can first rise in the cycle after that edge.
- Throughput: one point per cycle while `sink_ready`=1 and the FIFO is non-empty.
- Simultaneous push and pop on a full FIFO: occupancy is unchanged and no drop occurs.
- Simultaneous push and pop on an empty FIFO cannot happen.
- `inverse` changes only on the IDLE-to-STREAM edge or on an eop transfer edge.

## Test plan
Bench parameters: N=8 (PTS_LOG2=3), D=4, DATA_W=16.
- Basic frame: `enable`=1, `sink_ready`=1, push 1..8 one per cycle.
  - Required: 8 transfers, values 1..8.
  - `sink_sop` only with value 1; `sink_eop` only with value 8.
  - `frame_count`=1; `overflow`=0.
- Backpressure: hold `sink_ready`=0 for 3 cycles with head=5.
  - Required: `sink_valid`=1 and data=5 held stable.
  - No index advance; 5 is transferred once `sink_ready` returns.
- Overflow: `sink_ready`=0, push 6 samples.
  - Required: 4 stored; samples 5 and 6 dropped; `overflow`=1 sticky.
  - Full-FIFO push coinciding with a pop is not counted as a drop.
- Direction and enable: `inverse_req`=1 during frame 1, toggled mid-frame; `enable` dropped at point 3 of frame 2.
  - Required: `inverse` constant within each frame.
  - Frame 2 completes all 8 points, then IDLE with `sink_valid`=0.
- Reset mid-frame: assert `reset` after 5 transfers.
  - Required: next cycle all outputs at reset values.
  - After release, the next transfer carries `sink_sop`=1 and `frame_count`=0.
- Underrun: push with 1-cycle gaps.
  - Required: `sink_valid` gaps; sop/eop stay on points 0/7; no extra or missing points.

Source files
------------

// File: rtl/fft_frame_feeder_if.sv
// Avalon-ST sink bus between the frame feeder (master) and the FFT core (slave).
interface fft_frame_feeder_if #(
    parameter int DATA_W = 16
);
    logic              sink_valid;
    logic              sink_ready;
    logic              sink_sop;
    logic              sink_eop;
    logic [DATA_W-1:0] sink_real;
    logic [DATA_W-1:0] sink_imag;
    logic [1:0]        sink_error;

    modport master (
        output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
        input  sink_ready
    );

    modport slave (
        input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
        output sink_ready
    );
endinterface

// File: rtl/fft_frame_feeder.sv
// Frames a free-running audio sample stream into N-point Avalon-ST packets for the FFT sink.
//   state    | meaning
//   S_IDLE   | not streaming; FIFO keeps filling, waits for enable
//   S_STREAM | presenting FIFO head to the FFT core, counting frame points
module fft_frame_feeder #(
    parameter int DATA_W    = 16,
    parameter int PTS_LOG2  = 10,
    parameter int FIFO_LOG2 = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    in_sample,
    input  logic                 in_valid,
    input  logic                 enable,
    input  logic                 inverse_req,
    fft_frame_feeder_if.master   sink,
    output logic                 inverse,
    output logic [PTS_LOG2:0]    fft_pts,
    output logic                 overflow,
    output logic [15:0]          frame_count
);
    localparam int D     = 1 << FIFO_LOG2;
    localparam int CNT_W = FIFO_LOG2 + 1;
    localparam logic [PTS_LOG2-1:0] IDX_LAST = '1;

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t               r_state;
    logic [DATA_W-1:0]    r_mem [D];
    logic [FIFO_LOG2-1:0] r_rd_ptr;
    logic [FIFO_LOG2-1:0] r_wr_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [PTS_LOG2-1:0]  r_idx;
    logic                 r_inverse;
    logic                 r_overflow;
    logic [15:0]          r_frame_count;

    logic w_empty;
    logic w_full;
    logic w_valid;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_last;

    // Occupancy never exceeds D, so its MSB alone marks a full FIFO.
    assign w_empty = (r_count == '0);
    assign w_full  = r_count[FIFO_LOG2];
    assign w_valid = (r_state == S_STREAM) && !w_empty;
    assign w_pop   = w_valid && sink.sink_ready;
    assign w_push  = in_valid && (!w_full || w_pop);
    assign w_drop  = in_valid && w_full && !w_pop;
    assign w_last  = (r_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_LOG2'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // A frame, once started, always runs to its eop; enable is only looked at there.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_inverse     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state   <= S_STREAM;
                        r_inverse <= inverse_req;
                        r_idx     <= '0;
                    end
                end
                S_STREAM: begin
                    if (w_pop) begin
                        if (w_last) begin
                            r_idx         <= '0;
                            r_frame_count <= r_frame_count + 16'd1;
                            if (enable) begin
                                r_inverse <= inverse_req;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_idx <= r_idx + PTS_LOG2'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sink.sink_valid = w_valid;
    assign sink.sink_sop   = w_valid && (r_idx == '0);
    assign sink.sink_eop   = w_valid && w_last;
    assign sink.sink_real  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign sink.sink_imag  = '0;
    assign sink.sink_error = 2'b00;

    assign inverse     = r_inverse;
    assign fft_pts     = (PTS_LOG2 + 1)'(1) << PTS_LOG2;
    assign overflow    = r_overflow;
    assign frame_count = r_frame_count;
endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based frame model.
module tb_fft_frame_feeder;
    localparam int DW = 16;
    localparam int PL = 3;
    localparam int FL = 2;
    localparam int N  = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_sample;
    logic          in_valid;
    logic          enable;
    logic          inverse_req;
    logic          inverse;
    logic [PL:0]   fft_pts;
    logic          overflow;
    logic [15:0]   frame_count;

    fft_frame_feeder_if #(.DATA_W(DW)) sink_if ();

    fft_frame_feeder #(.DATA_W(DW), .PTS_LOG2(PL), .FIFO_LOG2(FL)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_sample   (in_sample),
        .in_valid    (in_valid),
        .enable      (enable),
        .inverse_req (inverse_req),
        .sink        (sink_if),
        .inverse     (inverse),
        .fft_pts     (fft_pts),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: FIFO as a queue, frame position as a plain integer
    int  m_q[$];
    bit  m_armed  = 1'b0;
    bit  m_stream = 1'b0;
    int  m_idx    = 0;
    bit  m_inv    = 1'b0;
    bit  m_ovf    = 1'b0;
    int  m_fc     = 0;

    logic          o_valid, o_sop, o_eop, o_inv, o_ovf;
    logic [DW-1:0] o_real;
    logic [15:0]   o_fc;

    int x_val[$];
    bit x_sop[$];
    bit x_eop[$];
    bit x_inv[$];
    int gaps;

    task automatic clr_log();
        x_val.delete();
        x_sop.delete();
        x_eop.delete();
        x_inv.delete();
        gaps = 0;
    endtask

    task automatic cyc(input bit v, input int s, input bit en, input bit ir,
                       input bit rdy, input bit rst);
        bit e_valid;
        bit pop;
        bit full;
        @(negedge clk);
        in_valid           = v;
        in_sample          = 16'(s);
        enable             = en;
        inverse_req        = ir;
        sink_if.sink_ready = rdy;
        reset              = rst;
        #1;
        o_valid = sink_if.sink_valid;
        o_sop   = sink_if.sink_sop;
        o_eop   = sink_if.sink_eop;
        o_real  = sink_if.sink_real;
        o_inv   = inverse;
        o_ovf   = overflow;
        o_fc    = frame_count;
        e_valid = m_stream && (m_q.size() > 0);
        if (m_armed) begin
            chk("valid", o_valid, e_valid);
            chk("sop", o_sop, e_valid && (m_idx == 0));
            chk("eop", o_eop, e_valid && (m_idx == N - 1));
            if (e_valid) chk("real", o_real, m_q[0]);
            chk("inverse", o_inv, m_inv);
            chk("overflow", o_ovf, m_ovf);
            chk("frame_count", o_fc, 16'(m_fc));
            chk("fft_pts", fft_pts, N);
            chk("imag", sink_if.sink_imag, 0);
            chk("error", sink_if.sink_error, 0);
        end
        if (o_valid === 1'b1 && rdy) begin
            x_val.push_back(int'(o_real));
            x_sop.push_back(o_sop);
            x_eop.push_back(o_eop);
            x_inv.push_back(o_inv);
        end
        if (o_valid !== 1'b1) gaps++;
        if (rst) begin
            m_q.delete();
            m_armed  = 1'b1;
            m_stream = 1'b0;
            m_idx    = 0;
            m_inv    = 1'b0;
            m_ovf    = 1'b0;
            m_fc     = 0;
        end else begin
            pop  = e_valid && rdy;
            full = (m_q.size() >= D);
            if (pop) void'(m_q.pop_front());
            if (v) begin
                if (!full || pop) m_q.push_back(s & 16'hFFFF);
                else m_ovf = 1'b1;
            end
            if (!m_stream) begin
                if (en) begin
                    m_stream = 1'b1;
                    m_inv    = ir;
                    m_idx    = 0;
                end
            end else if (pop) begin
                if (m_idx == N - 1) begin
                    m_idx = 0;
                    m_fc  = (m_fc + 1) % 65536;
                    if (en) m_inv = ir;
                    else m_stream = 1'b0;
                end else begin
                    m_idx++;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic chk_frame(input string tag, input int first, input int step_gap);
        chk({tag, "_n"}, x_val.size(), N);
        for (int k = 0; k < x_val.size() && k < N; k++) begin
            chk({tag, "_val"}, x_val[k], first + k * step_gap);
            chk({tag, "_sop"}, x_sop[k], k == 0);
            chk({tag, "_eop"}, x_eop[k], k == N - 1);
        end
    endtask

    initial begin
        bit r_en;
        in_valid = 0; in_sample = 0; enable = 0; inverse_req = 0;
        sink_if.sink_ready = 0; reset = 1;

        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_real", o_real, 0);
        chk("rst_fc", o_fc, 0);
        chk("rst_inv", o_inv, 0);

        // basic frame
        clr_log();
        for (int i = 1; i <= 8; i++) cyc(1, i, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 0);
        chk_frame("basic", 1, 1);
        chk("basic_fc", o_fc, 1);
        chk("basic_ovf", o_ovf, 0);

        // backpressure with head = 5
        clr_log();
        for (int i = 1; i <= 5; i++) cyc(1, i, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 0, 0);
            chk("bp_valid", o_valid, 1);
            chk("bp_real", o_real, 5);
            chk("bp_eop", o_eop, 0);
        end
        cyc(1, 6, 1, 0, 1, 0);
        cyc(1, 7, 1, 0, 1, 0);
        cyc(1, 8, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 0);
        chk_frame("bp", 1, 1);
        chk("bp_fc", o_fc, 2);

        // overflow: 6 pushes into a 4-deep FIFO, then a full push coinciding with a pop
        clr_log();
        for (int i = 0; i < 6; i++) cyc(1, 10 + i, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("ovf_set", o_ovf, 1);
        chk("ovf_head", o_real, 10);
        cyc(1, 16, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 1, 0);
        for (int i = 17; i <= 19; i++) cyc(1, i, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 0);
        chk("ovf_n", x_val.size(), 8);
        if (x_val.size() == 8) begin
            chk("ovf_v0", x_val[0], 10);
            chk("ovf_v3", x_val[3], 13);
            chk("ovf_v4", x_val[4], 16);
            chk("ovf_v7", x_val[7], 19);
            chk("ovf_eop", x_eop[7], 1);
        end
        chk("ovf_sticky", o_ovf, 1);
        chk("ovf_fc", o_fc, 3);

        // direction latch and enable drop at point 3 of frame 2
        cyc(0, 0, 0, 0, 0, 1);
        clr_log();
        for (int i = 0; i < 16; i++) cyc(1, 100 + i, i < 12, i < 4, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
        chk("dir_n", x_val.size(), 16);
        for (int k = 0; k < x_val.size(); k++) begin
            chk("dir_inv", x_inv[k], k < 8);
            chk("dir_val", x_val[k], 100 + k);
        end
        if (x_val.size() == 16) chk("dir_eop2", x_eop[15], 1);
        chk("dir_idle_valid", o_valid, 0);
        chk("dir_fc", o_fc, 2);
        cyc(1, 200, 0, 1, 1, 0);
        cyc(1, 201, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("idle_valid", o_valid, 0);
        chk("idle_inv", o_inv, 0);

        // reset mid-frame after 5 transfers
        cyc(0, 0, 0, 0, 0, 1);
        clr_log();
        for (int i = 0; i < 6; i++) cyc(1, i + 1, 1, 0, 1, 0);
        chk("mid_pre_n", x_val.size(), 5);
        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 0, 1, 0, 1, 0);
        chk("mid_valid", o_valid, 0);
        chk("mid_sop", o_sop, 0);
        chk("mid_eop", o_eop, 0);
        chk("mid_real", o_real, 0);
        chk("mid_inv", o_inv, 0);
        chk("mid_fc", o_fc, 0);
        cyc(1, 50, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 0);
        chk("mid_next_valid", o_valid, 1);
        chk("mid_next_sop", o_sop, 1);
        chk("mid_next_real", o_real, 50);
        chk("mid_next_fc", o_fc, 0);

        // underrun: one-cycle gaps between samples
        cyc(0, 0, 0, 0, 0, 1);
        clr_log();
        for (int i = 0; i < 16; i++) begin
            cyc(1, 60 + i, 1, 0, 1, 0);
            cyc(0, 0, 1, 0, 1, 0);
        end
        cyc(0, 0, 1, 0, 1, 0);
        chk("ur_n", x_val.size(), 16);
        for (int k = 0; k < x_val.size(); k++) begin
            chk("ur_val", x_val[k], 60 + k);
            chk("ur_sop", x_sop[k], (k % N) == 0);
            chk("ur_eop", x_eop[k], (k % N) == N - 1);
        end
        chk("ur_gaps", gaps >= 15, 1);
        chk("ur_fc", o_fc, 2);

        // random traffic against the model
        cyc(0, 0, 0, 0, 0, 1);
        r_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) r_en = ~r_en;
            cyc($urandom_range(0, 99) < 60, $urandom_range(0, 65535), r_en,
                $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 70,
                $urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
